// File: rtl/mi_ram_pkg.sv
// Shared definitions for the ping/pong mass-state RAM: FSM encoding, bank
// indices and the packed-bus slice helper.
package mi_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ram_state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // Low bit index of lane idx in a packed bus of width-bit lanes.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mi_ram_bank.sv
// One state bank: a single write port and NUM_RD independent registered read
// ports. Read registers hold their value while their enable is low.
module mi_ram_bank
  import mi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 27,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RD     = 2
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [NUM_RD-1:0]                re,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [DATA_WIDTH-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (re[gi]) begin
          q_reg <= mem[raddr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH]];
        end
      end

      assign rdata[slice_lo(gi, DATA_WIDTH) +: DATA_WIDTH] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/mi_pingpong_state_ram.sv
// Ping/pong state memory: reads come from bank_sel, writes go to the other
// bank, roles swap on a step strobe, and a sweeper zeroes both banks.
module mi_pingpong_state_ram
  import mi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 27,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic                         swap,
  input  logic                         clear,
  output logic                         busy,
  output logic                         bank_sel
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  ram_state_t            state_reg;
  logic [ADDR_WIDTH-1:0] clr_addr_reg;
  logic                  busy_reg;
  logic                  bank_sel_reg;
  logic [NUM_RD-1:0]     rd_valid_reg;
  logic [NUM_RD-1:0]     rd_sel_reg;   // bank each port last read from
  logic [NUM_RD-1:0]     rd_seen_reg;  // port has read since reset

  logic                  clearing;
  logic                  wr_go;
  logic [NUM_RD-1:0]     rd_go;
  logic                  a_we, b_we;
  logic [ADDR_WIDTH-1:0] bank_waddr;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [NUM_RD-1:0]     a_re, b_re;
  logic [NUM_RD*DATA_WIDTH-1:0] a_rdata, b_rdata;

  assign clearing   = (state_reg == ST_CLEAR);
  assign wr_go      = !clearing && wr_en;
  assign rd_go      = clearing ? '0 : rd_en;

  // The sweep writes zero into both banks at once.
  assign a_we       = clearing || (wr_go && bank_sel_reg == BANK_B);
  assign b_we       = clearing || (wr_go && bank_sel_reg == BANK_A);
  assign bank_waddr = clearing ? clr_addr_reg : wr_addr;
  assign bank_wdata = clearing ? '0 : wr_data;
  assign a_re       = (bank_sel_reg == BANK_A) ? rd_go : '0;
  assign b_re       = (bank_sel_reg == BANK_B) ? rd_go : '0;

  mi_ram_bank #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD)
  ) u_bank_a (
    .clk(clk), .we(a_we), .waddr(bank_waddr), .wdata(bank_wdata),
    .re(a_re), .raddr(rd_addr), .rdata(a_rdata)
  );

  mi_ram_bank #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD)
  ) u_bank_b (
    .clk(clk), .we(b_we), .waddr(bank_waddr), .wdata(bank_wdata),
    .re(b_re), .raddr(rd_addr), .rdata(b_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
      busy_reg     <= 1'b1;
      bank_sel_reg <= BANK_A;
      rd_valid_reg <= '0;
      rd_sel_reg   <= '0;
      rd_seen_reg  <= '0;
    end else if (state_reg == ST_CLEAR) begin
      rd_valid_reg <= '0;
      clr_addr_reg <= clr_addr_reg + 1'b1;
      if (clr_addr_reg == LAST_ADDR) begin
        state_reg <= ST_IDLE;
        busy_reg  <= 1'b0;
      end
    end else begin
      rd_valid_reg <= rd_en;
      rd_sel_reg   <= (rd_en & {NUM_RD{bank_sel_reg}}) | (~rd_en & rd_sel_reg);
      rd_seen_reg  <= rd_seen_reg | rd_en;
      if (swap) begin
        bank_sel_reg <= ~bank_sel_reg;
      end
      if (clear) begin
        state_reg    <= ST_CLEAR;
        busy_reg     <= 1'b1;
        clr_addr_reg <= '0;
      end
    end
  end

  // Ports that have not read since reset present zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_out
      localparam int LO = slice_lo(gi, DATA_WIDTH);
      assign rd_data[LO +: DATA_WIDTH] =
        !rd_seen_reg[gi] ? '0 :
        (rd_sel_reg[gi] == BANK_B) ? b_rdata[LO +: DATA_WIDTH] : a_rdata[LO +: DATA_WIDTH];
    end
  endgenerate

  assign rd_valid = rd_valid_reg;
  assign busy     = busy_reg;
  assign bank_sel = bank_sel_reg;

endmodule
